// File: rtl/boreal_emu_pkg.sv
// Shared constants, frame sizing and state encoding for the ADS1299 slave emulator.
package boreal_emu_pkg;

    localparam logic [23:0] STATUS_HDR = 24'hC00000;
    localparam logic [7:0]  OPC_SDATAC = 8'h11;
    localparam logic [7:0]  OPC_RDATAC = 8'h10;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        SHIFT
    } emu_state_e;

    // One 24-bit status word followed by one 24-bit word per channel.
    function automatic int frame_bits(input int num_ch);
        return 24 + 24 * num_ch;
    endfunction

endpackage

// File: rtl/boreal_spi_edge_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus single-cycle
// rise/fall pulses taken from the synchronized level.
module boreal_spi_edge_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the pin through the metastability chain and keep one extra stage for edge detection.
    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Chain registers; reset to the idle level of the pin so no false edge appears after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/boreal_ads1299_emu.sv
// ADS1299 slave-side emulator: produces deterministic 8-channel frames at a
// fixed rate, flags them on drdy_n and shifts them out on miso (SPI mode 1).
// Optional macro BOREAL_EMU_STALL_EN lets stall_in suppress frame delivery.
module boreal_ads1299_emu
    import boreal_emu_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int SAMPLE_DIV = 400000,
    parameter int DRDY_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        drdy_n,
    input  logic        stall_in,
    output logic [15:0] frame_cnt,
    output logic [7:0]  overrun_cnt,
    output logic        rdatac_mode
);

    localparam int FB    = frame_bits(NUM_CH);
    localparam int BIT_W = $clog2(FB + 1);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int GAP_W = $clog2(DRDY_GAP + 2);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    boreal_spi_edge_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    boreal_spi_edge_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    boreal_spi_edge_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    emu_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [19:0]       sample_cnt_q, sample_cnt_d;
    logic [19:0]       shadow_q, shadow_d;
    logic              pend_q, pend_d;
    logic [19:0]       pend_sample_q, pend_sample_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]        word_idx_q, word_idx_d;
    logic [4:0]        wbit_q, wbit_d;
    logic              shift_valid_q, shift_valid_d;
    logic [6:0]        cmd_sr_q, cmd_sr_d;
    logic [2:0]        cmd_bits_q, cmd_bits_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              miso_q, miso_d;
    logic              drdy_n_q, drdy_n_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]        overrun_cnt_q, overrun_cnt_d;
    logic              rdatac_q, rdatac_d;

    logic        tick;
    logic        frame_ev;
    logic [19:0] sample_next;
    logic [23:0] cur_word;
    logic [7:0]  cmd_byte;
    logic        unused_sigs;

    assign tick        = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign sample_next = sample_cnt_q + 20'd1;
    assign cur_word    = (word_idx_q == 4'd0) ? STATUS_HDR : {word_idx_q - 4'd1, shadow_q};
    assign cmd_byte    = {cmd_sr_q, mosi_s};

`ifdef BOREAL_EMU_STALL_EN
    assign frame_ev    = tick & rdatac_q & ~stall_in;
    assign unused_sigs = &{1'b0, sclk_lvl, cs_lvl, mosi_rise, mosi_fall};
`else
    assign frame_ev    = tick & rdatac_q;
    assign unused_sigs = &{1'b0, sclk_lvl, cs_lvl, mosi_rise, mosi_fall, stall_in};
`endif

    // Next-state logic: sample divider, frame hand-off, SPI shift-out and command decode.
    always_comb begin
        state_d       = state_q;
        div_d         = tick ? '0 : div_q + DIV_W'(1);
        sample_cnt_d  = tick ? sample_next : sample_cnt_q;
        shadow_d      = shadow_q;
        pend_d        = pend_q;
        pend_sample_d = pend_sample_q;
        bit_cnt_d     = bit_cnt_q;
        word_idx_d    = word_idx_q;
        wbit_d        = wbit_q;
        shift_valid_d = shift_valid_q;
        cmd_sr_d      = cmd_sr_q;
        cmd_bits_d    = cmd_bits_q;
        gap_d         = gap_q;
        miso_d        = miso_q;
        drdy_n_d      = drdy_n_q;
        frame_cnt_d   = frame_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
        rdatac_d      = rdatac_q;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    // Command-only transaction: nothing valid to shift out.
                    state_d       = SHIFT;
                    shift_valid_d = 1'b0;
                    bit_cnt_d     = '0;
                    word_idx_d    = 4'd0;
                    wbit_d        = 5'd0;
                    cmd_bits_d    = 3'd0;
                    miso_d        = 1'b0;
                    pend_d        = frame_ev;
                    if (frame_ev) pend_sample_d = sample_next;
                end else if (frame_ev) begin
                    shadow_d = sample_next;
                    state_d  = READY;
                    drdy_n_d = 1'b0;
                end
            end

            READY: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) drdy_n_d = 1'b0;
                end
                if (cs_fall) begin
                    state_d       = SHIFT;
                    shift_valid_d = 1'b1;
                    bit_cnt_d     = '0;
                    word_idx_d    = 4'd0;
                    wbit_d        = 5'd0;
                    cmd_bits_d    = 3'd0;
                    miso_d        = 1'b0;
                    gap_d         = '0;
                    pend_d        = frame_ev;
                    if (frame_ev) pend_sample_d = sample_next;
                end else if (frame_ev) begin
                    if (overrun_cnt_q != 8'hFF) overrun_cnt_d = overrun_cnt_q + 8'd1;
                    shadow_d = sample_next;
                    gap_d    = GAP_W'(DRDY_GAP);
                    drdy_n_d = (DRDY_GAP != 0);
                end
            end

            SHIFT: begin
                if (frame_ev) begin
                    pend_d        = 1'b1;
                    pend_sample_d = sample_next;
                end
                if (sclk_rise) begin
                    drdy_n_d = 1'b1;
                    if (shift_valid_q && (bit_cnt_q < BIT_W'(FB))) begin
                        miso_d    = cur_word[5'd23 - wbit_q];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (wbit_q == 5'd23) begin
                            wbit_d     = 5'd0;
                            word_idx_d = word_idx_q + 4'd1;
                        end else begin
                            wbit_d = wbit_q + 5'd1;
                        end
                    end else begin
                        miso_d = 1'b0;
                    end
                end
                if (sclk_fall) begin
                    cmd_sr_d   = cmd_byte[6:0];
                    cmd_bits_d = cmd_bits_q + 3'd1;
                    if (cmd_bits_q == 3'd7) begin
                        if (cmd_byte == OPC_SDATAC) begin
                            rdatac_d = 1'b0;
                            drdy_n_d = 1'b1;
                            pend_d   = 1'b0;
                        end else if (cmd_byte == OPC_RDATAC) begin
                            rdatac_d = 1'b1;
                        end
                    end
                end
                if (cs_rise) begin
                    miso_d     = 1'b0;
                    cmd_bits_d = 3'd0;
                    if (shift_valid_q && (bit_cnt_q == BIT_W'(FB)))
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    if (pend_d) begin
                        shadow_d = pend_sample_d;
                        pend_d   = 1'b0;
                        state_d  = READY;
                        drdy_n_d = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        drdy_n_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

`ifdef BOREAL_EMU_STALL_EN
        if (stall_in) begin
            drdy_n_d = 1'b1;
            if (state_d == READY) begin
                state_d = IDLE;
                gap_d   = '0;
            end
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            div_q         <= '0;
            sample_cnt_q  <= '0;
            shadow_q      <= '0;
            pend_q        <= 1'b0;
            pend_sample_q <= '0;
            bit_cnt_q     <= '0;
            word_idx_q    <= '0;
            wbit_q        <= '0;
            shift_valid_q <= 1'b0;
            cmd_sr_q      <= '0;
            cmd_bits_q    <= '0;
            gap_q         <= '0;
            miso_q        <= 1'b0;
            drdy_n_q      <= 1'b1;
            frame_cnt_q   <= '0;
            overrun_cnt_q <= '0;
            rdatac_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            sample_cnt_q  <= sample_cnt_d;
            shadow_q      <= shadow_d;
            pend_q        <= pend_d;
            pend_sample_q <= pend_sample_d;
            bit_cnt_q     <= bit_cnt_d;
            word_idx_q    <= word_idx_d;
            wbit_q        <= wbit_d;
            shift_valid_q <= shift_valid_d;
            cmd_sr_q      <= cmd_sr_d;
            cmd_bits_q    <= cmd_bits_d;
            gap_q         <= gap_d;
            miso_q        <= miso_d;
            drdy_n_q      <= drdy_n_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
            rdatac_q      <= rdatac_d;
        end
    end

    assign miso        = miso_q;
    assign drdy_n      = drdy_n_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_cnt_q;
    assign rdatac_mode = rdatac_q;

endmodule

// File: tb/tb_boreal_ads1299_emu.sv
// Directed testbench for boreal_ads1299_emu with SAMPLE_DIV=1000.
// Stall scenarios depend on BOREAL_EMU_STALL_EN.
module tb_boreal_ads1299_emu;

    localparam int NUM_CH     = 8;
    localparam int SAMPLE_DIV = 1000;
    localparam int DRDY_GAP   = 4;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        drdy_n;
    logic        stall_in;
    logic [15:0] frame_cnt;
    logic [7:0]  overrun_cnt;
    logic        rdatac_mode;

    int checks = 0;
    int errors = 0;

    logic [215:0] rd;
    logic [23:0]  exp_w;
    logic [23:0]  got_w;
    int           n;
    int           w;

    boreal_ads1299_emu #(
        .NUM_CH(NUM_CH), .SAMPLE_DIV(SAMPLE_DIV), .DRDY_GAP(DRDY_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .drdy_n(drdy_n), .stall_in(stall_in),
        .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt), .rdatac_mode(rdatac_mode)
    );

    // 100 MHz system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for a few cycles with SPI pins idle, then release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; stall_in = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Mode-1 master: mosi driven on sclk rise, miso captured just before sclk fall.
    task automatic spi_xfer(input int nbits, input logic [7:0] cmd, output logic [215:0] data);
        logic [215:0] acc;
        acc = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            mosi = (i < 8) ? cmd[7-i] : 1'b0;
            repeat (4) @(negedge clk);
            acc  = {acc[214:0], miso};
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        data = acc;
    endtask

    // Wait (bounded) for drdy_n to go low; returns negedges waited.
    task automatic wait_drdy_low(input int limit, output int waited);
        waited = 0;
        while (drdy_n !== 1'b0 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; stall_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (drdy_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_drdy: got %b expected 1", drdy_n); end
        checks++; if (miso !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso: got %b expected 0", miso); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_overrun: got %0d expected 0", overrun_cnt); end
        checks++; if (rdatac_mode !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdatac: got %b expected 1", rdatac_mode); end
        rst_n = 1'b1;
        wait_drdy_low(2000, n);
        checks++;
        if (n < 999 || n > 1002) begin errors++; $display("[TB] FAIL first_drdy_time: got %0d cycles expected 999..1002", n); end
        spi_xfer(216, 8'h00, rd);
        for (int k = 0; k <= NUM_CH; k++) begin
            exp_w = (k == 0) ? 24'hC00000 : {4'(k - 1), 20'd1};
            got_w = rd[215 - 24*k -: 24];
            checks++;
            if (got_w !== exp_w) begin errors++; $display("[TB] FAIL first_frame_word%0d: got %h expected %h", k, got_w, exp_w); end
        end
        repeat (6) @(negedge clk);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL first_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_overrun();
        do_reset();
        wait_drdy_low(1100, n);
        checks++; if (drdy_n !== 1'b0) begin errors++; $display("[TB] FAIL ovr_first_drdy: got %b expected 0", drdy_n); end
        for (int p = 0; p < 2; p++) begin
            n = 0;
            while (drdy_n !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
            w = 0;
            while (drdy_n === 1'b1 && w < 20) begin w++; @(negedge clk); end
            checks++;
            if (w != DRDY_GAP) begin errors++; $display("[TB] FAIL ovr_gap_pulse%0d: got %0d cycles expected %0d", p, w, DRDY_GAP); end
        end
        checks++; if (overrun_cnt !== 8'd2) begin errors++; $display("[TB] FAIL ovr_count: got %0d expected 2", overrun_cnt); end
        spi_xfer(216, 8'h00, rd);
        for (int k = 0; k <= NUM_CH; k++) begin
            exp_w = (k == 0) ? 24'hC00000 : {4'(k - 1), 20'd3};
            got_w = rd[215 - 24*k -: 24];
            checks++;
            if (got_w !== exp_w) begin errors++; $display("[TB] FAIL ovr_frame_word%0d: got %h expected %h", k, got_w, exp_w); end
        end
        repeat (6) @(negedge clk);
        checks++; if (overrun_cnt !== 8'd2) begin errors++; $display("[TB] FAIL ovr_count_after_read: got %0d expected 2", overrun_cnt); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL ovr_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_tick_mid_read();
        do_reset();
        repeat (5100) @(negedge clk);
        checks++; if (drdy_n !== 1'b0) begin errors++; $display("[TB] FAIL mid_drdy_ready: got %b expected 0", drdy_n); end
        spi_xfer(216, 8'h00, rd);
        n = 0;
        while (drdy_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n < 2 || n > 5) begin errors++; $display("[TB] FAIL mid_drdy_after_cs: got %0d cycles expected 2..5", n); end
        for (int k = 0; k <= NUM_CH; k++) begin
            exp_w = (k == 0) ? 24'hC00000 : {4'(k - 1), 20'd5};
            got_w = rd[215 - 24*k -: 24];
            checks++;
            if (got_w !== exp_w) begin errors++; $display("[TB] FAIL mid_inflight_word%0d: got %h expected %h", k, got_w, exp_w); end
        end
        spi_xfer(216, 8'h00, rd);
        got_w = rd[191:168];
        checks++; if (got_w !== 24'h000006) begin errors++; $display("[TB] FAIL mid_pending_ch0: got %h expected 000006", got_w); end
        got_w = rd[23:0];
        checks++; if (got_w !== 24'h700006) begin errors++; $display("[TB] FAIL mid_pending_ch7: got %h expected 700006", got_w); end
        repeat (6) @(negedge clk);
        checks++; if (overrun_cnt !== 8'd4) begin errors++; $display("[TB] FAIL mid_overrun: got %0d expected 4", overrun_cnt); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL mid_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_commands();
        int lows;
        do_reset();
        wait_drdy_low(1100, n);
        spi_xfer(8, 8'h11, rd);
        repeat (6) @(negedge clk);
        checks++; if (rdatac_mode !== 1'b0) begin errors++; $display("[TB] FAIL cmd_sdatac_mode: got %b expected 0", rdatac_mode); end
        checks++; if (drdy_n !== 1'b1) begin errors++; $display("[TB] FAIL cmd_sdatac_drdy: got %b expected 1", drdy_n); end
        lows = 0;
        repeat (5000) begin
            @(negedge clk);
            if (drdy_n !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("[TB] FAIL cmd_sdatac_quiet: got %0d low cycles expected 0", lows); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL cmd_frame_cnt: got %0d expected 0", frame_cnt); end
        spi_xfer(8, 8'h10, rd);
        repeat (6) @(negedge clk);
        checks++; if (rdatac_mode !== 1'b1) begin errors++; $display("[TB] FAIL cmd_rdatac_mode: got %b expected 1", rdatac_mode); end
        wait_drdy_low(1100, n);
        checks++; if (drdy_n !== 1'b0) begin errors++; $display("[TB] FAIL cmd_rdatac_drdy: got %b expected 0", drdy_n); end
        spi_xfer(216, 8'h00, rd);
        got_w = rd[215:192];
        checks++; if (got_w !== 24'hC00000) begin errors++; $display("[TB] FAIL cmd_resume_status: got %h expected C00000", got_w); end
        got_w = rd[191:168];
        checks++; if (got_w !== 24'h000007) begin errors++; $display("[TB] FAIL cmd_resume_ch0: got %h expected 000007", got_w); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL cmd_overrun: got %0d expected 0", overrun_cnt); end
    endtask

    task automatic test_short_read();
        do_reset();
        wait_drdy_low(1100, n);
        spi_xfer(100, 8'h00, rd);
        got_w = rd[99:76];
        checks++; if (got_w !== 24'hC00000) begin errors++; $display("[TB] FAIL short_status: got %h expected C00000", got_w); end
        got_w = rd[75:52];
        checks++; if (got_w !== 24'h000001) begin errors++; $display("[TB] FAIL short_ch0: got %h expected 000001", got_w); end
        repeat (6) @(negedge clk);
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL short_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (drdy_n !== 1'b1) begin errors++; $display("[TB] FAIL short_discard_drdy: got %b expected 1", drdy_n); end
        wait_drdy_low(1200, n);
        spi_xfer(216, 8'h00, rd);
        got_w = rd[191:168];
        checks++; if (got_w !== 24'h000002) begin errors++; $display("[TB] FAIL short_next_ch0: got %h expected 000002", got_w); end
        repeat (6) @(negedge clk);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL short_next_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL short_overrun: got %0d expected 0", overrun_cnt); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        wait_drdy_low(1100, n);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (miso !== 1'b1) begin errors++; $display("[TB] FAIL rmid_msb: got %b expected 1", miso); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (miso !== 1'b0) begin errors++; $display("[TB] FAIL rmid_miso: got %b expected 0", miso); end
        checks++; if (drdy_n !== 1'b1) begin errors++; $display("[TB] FAIL rmid_drdy: got %b expected 1", drdy_n); end
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef BOREAL_EMU_STALL_EN
    task automatic test_stall();
        int lows;
        do_reset();
        stall_in = 1'b1;
        lows = 0;
        repeat (10500) begin
            @(negedge clk);
            if (drdy_n !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("[TB] FAIL stall_quiet: got %0d low cycles expected 0", lows); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL stall_overrun: got %0d expected 0", overrun_cnt); end
        stall_in = 1'b0;
        wait_drdy_low(1100, n);
        spi_xfer(216, 8'h00, rd);
        got_w = rd[191:168];
        checks++; if (got_w !== 24'h00000B) begin errors++; $display("[TB] FAIL stall_release_ch0: got %h expected 00000B", got_w); end
    endtask
`else
    task automatic test_stall();
        do_reset();
        stall_in = 1'b1;
        wait_drdy_low(1100, n);
        checks++; if (drdy_n !== 1'b0) begin errors++; $display("[TB] FAIL stall_ignored_drdy: got %b expected 0", drdy_n); end
        stall_in = 1'b0;
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] starting boreal_ads1299_emu bench");
        test_reset();
        test_overrun();
        test_tick_mid_read();
        test_commands();
        test_short_read();
        test_reset_mid_read();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boreal_ads1299_emu.md
Name: boreal_ads1299_emu

Overview:
- Synthesizable ADS1299 slave-side emulator. It is the far end of the biopotential SPI link that boreal_spi_chain masters.
- Generates deterministic 8-channel frames at a fixed sample rate, signals them on drdy_n, and shifts them out on miso (SPI mode 1).
- Decodes SDATAC/RDATAC opcodes on mosi.
- Used for hardware-in-loop bring-up and for watchdog/fusion regression without a physical AFE.

Parameters:
- NUM_CH, 8, channel words per frame (1..8).
- SAMPLE_DIV, 400000, clk cycles per sample (250 SPS at 100 MHz); minimum 64.
- DRDY_GAP, 4, clk cycles drdy_n is held high before re-asserting on an unread frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sclk  in  1  SPI clock from master, asynchronous to clk
- cs_n  in  1  SPI chip select, active low
- mosi  in  1  master-to-slave command data
- miso  out  1  slave-to-master frame data
- drdy_n  out  1  data-ready, active low
- stall_in  in  1  DRDY suppression request (honoured only with the macro)
- frame_cnt  out  16  frames completely read, wrapping
- overrun_cnt  out  8  frames replaced unread, saturating at 255
- rdatac_mode  out  1  1 = continuous-read mode

Behaviour:
- Clocking: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values: miso=0, drdy_n=1, frame_cnt=0, overrun_cnt=0, rdatac_mode=1. Sample counter, divider, bit counter and pending flag are all 0.
- Input sync: sclk, cs_n and mosi pass through 2-flop synchronizers, followed by edge detect. Pin-to-internal-edge latency is 3 clk. Master SCLK half-period must be ≥4 clk.
- Frame format: FRAME_BITS = 24 + 24·NUM_CH.
  - Word 0 is status 24'hC00000.
  - Channel k is {k[3:0], sample_cnt[19:0]}, MSB first, channel 0 first.
- Sample tick: the divider counts 0..SAMPLE_DIV-1. On wrap, sample_cnt increments (20-bit, wraps) and a frame event occurs.
- Frame event in state IDLE (cs_n high, no unread frame, rdatac_mode=1): load the shadow frame and set drdy_n=0 on the next clk.
- Frame event while a frame is unread (drdy_n=0 and cs_n high):
  - overrun_cnt increments (saturating) and the shadow frame is replaced.
  - drdy_n goes high for DRDY_GAP cycles, then low again.
- Frame event during an active read (cs_n low): set pending. On the cs_n rising edge, load the pending frame and drop drdy_n 1 clk later. No tearing of an in-flight frame.
- State machine: IDLE → READY (drdy_n=0) → SHIFT (cs_n falls) → IDLE (cs_n rises).
  - In SHIFT, drdy_n returns high on the first sclk rising edge.
  - On each sclk rising edge, miso presents the next bit (first rising edge gives the MSB).
  - After FRAME_BITS bits, miso=0.
  - frame_cnt increments on cs_n rise only if bit count ≥ FRAME_BITS. A short read counts neither frame nor overrun, and the frame is discarded.
- Commands: mosi is sampled on sclk falling edges, MSB first, in 8-bit groups while cs_n is low. The byte counter clears on cs_n rise.
  - 0x11 SDATAC: rdatac_mode=0, drdy_n=1, frame events ignored.
  - 0x10 RDATAC: rdatac_mode=1; the next tick produces a frame.
  - Other opcodes are ignored. Command bytes and data shift-out coexist in the same transaction.
- Reset mid-read: all state returns to reset values in the same cycle, and miso=0 immediately after.
- cs_n toggled with no sclk edges: READY→SHIFT→IDLE, frame discarded, no counters change.

Optional Feature:
- Macro BOREAL_EMU_STALL_EN.
  - Defined: while stall_in=1, frame events are dropped (sample_cnt still advances) and drdy_n is held high. This exercises boreal_watchdog timeout.
  - Undefined: stall_in is ignored; behaviour is exactly as above.

Decomposition:
- Package boreal_emu_pkg holds:
  - STATUS_HDR=24'hC00000, OPC_SDATAC=8'h11, OPC_RDATAC=8'h10
  - FRAME_BITS function of NUM_CH
  - state enum {IDLE, READY, SHIFT}
- Sub-module boreal_spi_edge_sync: 2-flop synchronizer plus rise/fall pulse outputs for one input. Instantiated three times.

Test Plan:
- Reset, SAMPLE_DIV=1000: drdy_n falls at cycle 1001 ±1. A full 216-bit mode-1 read returns C00000, 000001, 100001, …, 700001; frame_cnt=1.
- No reads for 3 ticks: overrun_cnt=2; each replacement shows a 4-cycle drdy_n high pulse; the next read returns sample_cnt=3.
- Tick mid-read (cs_n low at sample_cnt=5): the in-flight frame is intact (sample 5). drdy_n falls 1 clk after cs_n rise, carrying sample 6.
- Send 0x11 on mosi: rdatac_mode=0, no drdy_n for 5 ticks. Send 0x10: drdy_n is back on the next tick.
- Read of 100 bits then cs_n high: frame_cnt unchanged; the next frame is delivered normally.
- With BOREAL_EMU_STALL_EN, stall_in=1 for 10 ticks: drdy_n stays high and overrun_cnt=0. On release, the next frame carries sample_cnt advanced by 10.
